mlu_bootstrap: RTL
==================

MLU_BOOTSTRAP -- requirements
Module: mlu_bootstrap

Interface
REQ-001 Parameter SLICE_DEPTH, default 4096, SHALL set the number of slice-table bytes loaded.
REQ-002 Parameter LA_DEPTH, default 131072, SHALL set the number of lookahead-table bytes loaded.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum ROM_ACK wait, in cycles.
REQ-004 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-006 ROM_REQ  out  1  SHALL be the byte read request to the boot ROM.
REQ-007 ROM_ADDR  out  18  SHALL be the ROM byte address.
REQ-008 ROM_ACK  in  1  SHALL indicate that ROM_DATA is valid for the current request.
REQ-009 ROM_DATA  in  8  SHALL be the ROM read data.
REQ-010 BOOTSTRAP_ADDR  out  17  SHALL be the table write address to the MLU.
REQ-011 BOOTSTRAP_DATA  out  8  SHALL be the table write data to the MLU.
REQ-012 BOOTSTRAP_MLU_SLICE_N_WE  out  1  SHALL be the active-low write strobe for all slice tables.
REQ-013 BOOTSTRAP_MLU_LOOKAHEAD_N_WE  out  1  SHALL be the active-low write strobe for the lookahead table.
REQ-014 N_BOOTED  out  1  SHALL be low only once both tables have loaded successfully.
REQ-015 ERR  out  1  SHALL be high after a ROM timeout.
REQ-016 REBOOT  in  1  SHALL request a reload; it is sampled only in DONE or FAIL.

Function
REQ-017 States SHALL be IDLE, S_READ, S_WRITE, S_HOLD, L_READ, L_WRITE, L_HOLD, DONE, FAIL.
REQ-018 IDLE SHALL go to S_READ on the first cycle after RST is low, with the byte index cleared to 0.
REQ-019 S_READ/L_READ SHALL hold ROM_REQ=1 with ROM_ADDR stable until ROM_ACK=1.
REQ-020 ROM_ACK SHALL be ignored while ROM_REQ=0.
REQ-021 Slice bytes SHALL use ROM_ADDR = index.
REQ-022 Lookahead bytes SHALL use ROM_ADDR = SLICE_DEPTH + index.
REQ-023 On ROM_ACK, ROM_DATA SHALL be latched into BOOTSTRAP_DATA and the FSM SHALL advance to S_WRITE/L_WRITE, with ROM_REQ=0 in that cycle.
REQ-024 S_WRITE/L_WRITE SHALL last exactly one cycle, with the matching N_WE=0 and the other N_WE=1.
REQ-025 S_HOLD/L_HOLD SHALL last exactly one cycle with both N_WE=1.
REQ-026 BOOTSTRAP_ADDR and BOOTSTRAP_DATA SHALL be stable from the WRITE cycle through the HOLD cycle.
REQ-027 BOOTSTRAP_ADDR SHALL equal index, zero-extended to 17 bits.
REQ-028 After S_HOLD, index SHALL increment and the FSM SHALL return to S_READ; when index = SLICE_DEPTH-1, index SHALL instead clear to 0 and the FSM SHALL go to L_READ.
REQ-029 After L_HOLD, index SHALL increment and the FSM SHALL return to L_READ; when index = LA_DEPTH-1, the FSM SHALL go to DONE.
REQ-030 The index SHALL never wrap.
REQ-031 In DONE, N_BOOTED SHALL be 0, both N_WE SHALL be 1 and ROM_REQ SHALL be 0.
REQ-032 In DONE, REBOOT=1 SHALL go to IDLE, with N_BOOTED=1 from the next cycle.
REQ-033 A wait counter SHALL clear on entry to each READ state and increment every cycle that ROM_ACK=0.
REQ-034 When the wait counter reaches TIMEOUT without ROM_ACK, the FSM SHALL go to FAIL.
REQ-035 FAIL SHALL hold ERR=1, N_BOOTED=1, ROM_REQ=0 and both N_WE=1.
REQ-036 In FAIL, REBOOT=1 SHALL go to IDLE and clear ERR.
REQ-037 A ROM_ACK in the same cycle as the wait counter reaching TIMEOUT SHALL take precedence, so that the byte is accepted.
REQ-038 Two N_WE strobes SHALL never be low in the same cycle.
REQ-039 Outside WRITE states, both N_WE SHALL be 1.
REQ-040 N_BOOTED SHALL be 1 in every state except DONE.

Reset
REQ-041 While RST=1 the FSM SHALL enter IDLE, from any state including mid-write, on the next edge.
REQ-042 Reset values SHALL be: ROM_REQ=0, ROM_ADDR=0, BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0, both N_WE=1, N_BOOTED=1, ERR=0, index=0, wait counter=0.
REQ-043 A write strobe that is low when RST is asserted SHALL be high from the next edge.

Verification
REQ-044 Nominal load: SLICE_DEPTH=4, LA_DEPTH=8, ROM byte = addr^0x5A, ROM_ACK one cycle after each ROM_REQ -> slice writes 0x5A,0x5B,0x58,0x59 at addr 0-3, then lookahead writes 0x5E..0x51 at addr 0-7, then N_BOOTED=0; 12 writes total, 48 cycles from RST falling.
REQ-045 ROM_ACK delayed 10 cycles on ROM_ADDR=2 -> ROM_REQ and ROM_ADDR stay stable for 10 cycles, no strobe, write data correct.
REQ-046 Timeout: ROM_ACK never asserted, TIMEOUT=255 -> FAIL after 255 wait cycles with ERR=1, N_BOOTED=1; REBOOT=1 -> ERR=0 and reload starts at ROM_ADDR=0.
REQ-047 RST asserted during the third lookahead WRITE -> both N_WE=1 next edge, N_BOOTED=1; after RST release the load restarts at ROM_ADDR=0.
REQ-048 REBOOT pulsed mid-load -> ignored; REBOOT pulsed in DONE -> N_BOOTED=1 next cycle and the full sequence repeats identically.
REQ-049 Every cycle -> at most one N_WE low; N_WE low only with BOOTSTRAP_ADDR and BOOTSTRAP_DATA equal to their values in the following cycle.

Source files
------------

// File: rtl/mlu_bootstrap.sv
// Boot loader that copies the slice and lookahead tables from the boot ROM into the MLU,
// one byte per READ / WRITE / HOLD sequence, and raises ERR if the ROM stops answering.
module mlu_bootstrap #(
  parameter int unsigned SLICE_DEPTH = 4096,
  parameter int unsigned LA_DEPTH    = 131072,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        ROM_REQ,
  output logic [17:0] ROM_ADDR,
  input  logic        ROM_ACK,
  input  logic [7:0]  ROM_DATA,
  output logic [16:0] BOOTSTRAP_ADDR,
  output logic [7:0]  BOOTSTRAP_DATA,
  output logic        BOOTSTRAP_MLU_SLICE_N_WE,
  output logic        BOOTSTRAP_MLU_LOOKAHEAD_N_WE,
  output logic        N_BOOTED,
  output logic        ERR,
  input  logic        REBOOT
);

  // The wait counter only ever needs to hold TIMEOUT-1: the next miss goes to FAIL.
  localparam int unsigned WaitW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [16:0] SliceLast   = 17'(SLICE_DEPTH - 1);
  localparam logic [16:0] LaLast      = 17'(LA_DEPTH - 1);
  localparam logic [17:0] LaBase      = 18'(SLICE_DEPTH);

  typedef enum logic [3:0] {
    StIdle,
    StSRead,
    StSWrite,
    StSHold,
    StLRead,
    StLWrite,
    StLHold,
    StDone,
    StFail
  } state_e;

  state_e            state_q, state_d;
  logic [16:0]       index_q, index_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [7:0]        data_q, data_d;
  logic              la_sel;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      index_q <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    wait_d  = wait_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        index_d = '0;
        wait_d  = '0;
        state_d = StSRead;
      end
      StSRead, StLRead: begin
        // An ACK arriving on the last permitted wait cycle still wins over the timeout.
        if (ROM_ACK) begin
          data_d  = ROM_DATA;
          state_d = (state_q == StSRead) ? StSWrite : StLWrite;
        end else if (wait_q == WaitLast) begin
          state_d = StFail;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StSWrite: state_d = StSHold;
      StLWrite: state_d = StLHold;
      StSHold: begin
        wait_d = '0;
        if (index_q == SliceLast) begin
          index_d = '0;
          state_d = StLRead;
        end else begin
          index_d = index_q + 17'd1;
          state_d = StSRead;
        end
      end
      StLHold: begin
        wait_d = '0;
        if (index_q == LaLast) begin
          state_d = StDone;
        end else begin
          index_d = index_q + 17'd1;
          state_d = StLRead;
        end
      end
      StDone, StFail: begin
        if (REBOOT) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ROM_REQ                      = 1'b0;
    BOOTSTRAP_MLU_SLICE_N_WE     = 1'b1;
    BOOTSTRAP_MLU_LOOKAHEAD_N_WE = 1'b1;
    N_BOOTED                     = 1'b1;
    ERR                          = 1'b0;
    la_sel                       = 1'b0;
    unique case (state_q)
      StSRead:  ROM_REQ = 1'b1;
      StLRead: begin
        ROM_REQ = 1'b1;
        la_sel  = 1'b1;
      end
      StSWrite: BOOTSTRAP_MLU_SLICE_N_WE = 1'b0;
      StLWrite: begin
        BOOTSTRAP_MLU_LOOKAHEAD_N_WE = 1'b0;
        la_sel                       = 1'b1;
      end
      StLHold:  la_sel = 1'b1;
      StDone:   N_BOOTED = 1'b0;
      StFail:   ERR = 1'b1;
      default:  la_sel = 1'b0;
    endcase
    ROM_ADDR = la_sel ? (LaBase + {1'b0, index_q}) : {1'b0, index_q};
  end

  assign BOOTSTRAP_ADDR = index_q;
  assign BOOTSTRAP_DATA = data_q;

endmodule
